udp_cmd_decoder: RTL

//   Downstream consumer of the UDP receive word stream (rec_en/rec_data/rec_pkt_done/rec_byte_num).

---
 rtl/udp_cmd_decoder_pkg.sv | 31 +++
 rtl/udp_cmd_decoder_sat_cnt16.sv | 22 ++
 rtl/udp_cmd_decoder.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/udp_cmd_decoder_pkg.sv
`timescale 1ns / 1ps
// Shared definitions for the UDP register-write command decoder.
//   - Default header constants (magic, write command, maximum length)
//   - FSM state encoding and per-packet error codes
//   - Helper returning the exact payload byte count of a well-formed packet
package udp_cmd_decoder_pkg;

  localparam logic [15:0] MagicDefault  = 16'hA55A;
  localparam logic [7:0]  CmdWrDefault  = 8'h01;
  localparam logic [7:0]  MaxLenDefault = 8'd64;

  typedef enum logic [1:0] {
    StIdle,
    StAddr,
    StData,
    StDrain
  } state_e;

  typedef enum logic [1:0] {
    ErrNone   = 2'd0,
    ErrBadHdr = 2'd1,
    ErrShort  = 2'd2,
    ErrLong   = 2'd3
  } err_e;

  // Header word + address word + len data words, 4 bytes each.
  function automatic logic [17:0] expected_bytes(input logic [7:0] len);
    return (18'(len) + 18'd2) << 2;
  endfunction

endpackage

// File: rtl/udp_cmd_decoder_sat_cnt16.sv
`timescale 1ns / 1ps
// 16-bit saturating event counter.
//   clk    in  clock
//   rst_n  in  asynchronous active-low reset (clears count)
//   inc    in  increment request, ignored once count reaches 16'hFFFF
//   count  out current count
module udp_cmd_decoder_sat_cnt16 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inc,
  output logic [15:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= 16'd0;
    end else if (inc && (count != 16'hFFFF)) begin
      count <= count + 16'd1;
    end
  end

endmodule

// File: rtl/udp_cmd_decoder.sv
`timescale 1ns / 1ps
// Register-write command decoder for the UDP receive word stream.
// Each payload is {MAGIC, cmd, len}, base address, then len data words; every data word
// becomes one registered write strobe at base+idx. Each packet ends with a one-cycle
// pkt_ok or pkt_err pulse, a held err_code and saturating ok/err counters.
//   clk, rst_n         receive clock, asynchronous active-low reset
//   rec_en, rec_data   one 32-bit payload word per rec_en
//   rec_pkt_done       end-of-packet pulse, rec_byte_num valid with it
//   reg_wr_en/addr/data register write strobe (1 cycle after accepting rec_en)
//   pkt_ok, pkt_err    per-packet result pulse (1 cycle after rec_pkt_done)
//   err_code           0 none, 1 bad header, 2 short, 3 long; held until next result
//   ok_cnt, err_cnt    saturating packet counters, updated with the result pulse
module udp_cmd_decoder
  import udp_cmd_decoder_pkg::*;
#(
  parameter logic [15:0] MAGIC   = MagicDefault,
  parameter logic [7:0]  CMD_WR  = CmdWrDefault,
  parameter logic [7:0]  MAX_LEN = MaxLenDefault,
  parameter int unsigned ADDR_W  = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rec_en,
  input  logic [31:0]       rec_data,
  input  logic              rec_pkt_done,
  input  logic [15:0]       rec_byte_num,
  output logic              reg_wr_en,
  output logic [ADDR_W-1:0] reg_wr_addr,
  output logic [31:0]       reg_wr_data,
  output logic              pkt_ok,
  output logic              pkt_err,
  output logic [1:0]        err_code,
  output logic [15:0]       ok_cnt,
  output logic [15:0]       err_cnt
);

  state_e            state_q, state_d;
  logic [7:0]        len_q, len_d;
  logic [7:0]        idx_q, idx_d;
  logic [ADDR_W-1:0] base_q, base_d;
  err_e              err_q, err_d;
  err_e              done_err;

  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [31:0]       wr_data_q, wr_data_d;
  logic              ok_q, ok_d;
  logic              fail_q, fail_d;
  logic [1:0]        err_code_q, err_code_d;

  logic              hdr_ok;

  assign hdr_ok = (rec_data[31:16] == MAGIC) && (rec_data[15:8] == CMD_WR) &&
                  (rec_data[7:0] != 8'd0) && (rec_data[7:0] <= MAX_LEN);

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    idx_d      = idx_q;
    base_d     = base_q;
    err_d      = err_q;
    done_err   = ErrNone;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    ok_d       = 1'b0;
    fail_d     = 1'b0;
    err_code_d = err_code_q;

    // The word is consumed first; a coincident end-of-packet is judged on the result.
    if (rec_en) begin
      unique case (state_q)
        StIdle: begin
          if (hdr_ok) begin
            len_d   = rec_data[7:0];
            state_d = StAddr;
          end else begin
            err_d   = ErrBadHdr;
            state_d = StDrain;
          end
        end
        StAddr: begin
          base_d  = rec_data[ADDR_W-1:0];
          idx_d   = 8'd0;
          state_d = StData;
        end
        StData: begin
          wr_en_d   = 1'b1;
          wr_addr_d = base_q + ADDR_W'(idx_q);  // wraps silently
          wr_data_d = rec_data;
          idx_d     = idx_q + 8'd1;
          if (idx_q == len_q - 8'd1) begin
            state_d = StDrain;
          end
        end
        StDrain: begin
          if (err_q != ErrBadHdr) begin
            err_d = ErrLong;
          end
        end
      endcase
    end

    if (rec_pkt_done) begin
      unique case (state_d)
        // Still idle means no word of this packet arrived: nothing to report.
        StIdle: begin
        end
        StAddr, StData: begin
          fail_d     = 1'b1;
          err_code_d = ErrShort;
        end
        StDrain: begin
          done_err = err_d;
          if ((done_err == ErrNone) && (18'(rec_byte_num) > expected_bytes(len_d))) begin
            done_err = ErrLong;
          end
          if (done_err == ErrNone) begin
            ok_d = 1'b1;
          end else begin
            fail_d = 1'b1;
          end
          err_code_d = done_err;
        end
      endcase
      state_d = StIdle;
      len_d   = 8'd0;
      idx_d   = 8'd0;
      err_d   = ErrNone;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      len_q      <= 8'd0;
      idx_q      <= 8'd0;
      base_q     <= '0;
      err_q      <= ErrNone;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= 32'd0;
      ok_q       <= 1'b0;
      fail_q     <= 1'b0;
      err_code_q <= 2'd0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      idx_q      <= idx_d;
      base_q     <= base_d;
      err_q      <= err_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      ok_q       <= ok_d;
      fail_q     <= fail_d;
      err_code_q <= err_code_d;
    end
  end

  assign reg_wr_en   = wr_en_q;
  assign reg_wr_addr = wr_addr_q;
  assign reg_wr_data = wr_data_q;
  assign pkt_ok      = ok_q;
  assign pkt_err     = fail_q;
  assign err_code    = err_code_q;

  // Driven from next-state pulses so counts change on the same edge as pkt_ok/pkt_err.
  udp_cmd_decoder_sat_cnt16 u_ok_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (ok_d),
    .count (ok_cnt)
  );

  udp_cmd_decoder_sat_cnt16 u_err_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (fail_d),
    .count (err_cnt)
  );

endmodule
